// File: rtl/space_monsters_pkg.sv
// Shared constants for the space monsters game: one-hot state codes,
// screen bounds, formation cell pitch and per-level march periods.
package space_monsters_pkg;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_LOAD  = 5'b00010;
  localparam logic [4:0] ST_MARCH = 5'b00100;
  localparam logic [4:0] ST_WON   = 5'b01000;
  localparam logic [4:0] ST_LOST  = 5'b10000;

  localparam int X_MIN  = 144;
  localparam int X_MAX  = 784;
  localparam int Y_TANK = 450;

  localparam int CELL_W = 40;
  localparam int CELL_H = 30;

  localparam int unsigned STEP_L1 = 12500000;
  localparam int unsigned STEP_L2 = 6250000;

  function automatic logic level_ok(input logic [2:0] lvl);
    return (lvl == 3'd1) || (lvl == 3'd2);
  endfunction

endpackage

// File: rtl/monster_wave_ctrl_lowest_alive_row.sv
// Priority encoder over the alive bitmap: index of the bottom-most row
// that still holds a live monster, plus a flag for any monster alive.
module lowest_alive_row #(
  parameter int ROWS = 3,
  parameter int COLS = 8,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS*COLS-1:0] alive,
  output logic [RW-1:0]        row_idx,
  output logic                 any_alive
);

  // Later (lower on screen) rows overwrite earlier ones
  always_comb begin
    row_idx   = '0;
    any_alive = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (|alive[r*COLS +: COLS]) begin
        row_idx   = RW'(r);
        any_alive = 1'b1;
      end
    end
  end

endmodule

// File: rtl/monster_wave_ctrl.sv
// Monster formation controller for one level: alive bitmap, marching
// origin, bullet hits, kill score and win / tank-destroyed outcomes.
module monster_wave_ctrl #(
  parameter int          ROWS    = 3,
  parameter int          COLS    = 8,
  parameter int          CELL_W  = space_monsters_pkg::CELL_W,
  parameter int          CELL_H  = space_monsters_pkg::CELL_H,
  parameter int          STEP_X  = 8,
  parameter int          DROP_Y  = 15,
  parameter int          X_MIN   = space_monsters_pkg::X_MIN,
  parameter int          X_MAX   = space_monsters_pkg::X_MAX,
  parameter int          Y_START = 75,
  parameter int          Y_TANK  = space_monsters_pkg::Y_TANK,
  parameter int unsigned STEP_L1 = space_monsters_pkg::STEP_L1,
  parameter int unsigned STEP_L2 = space_monsters_pkg::STEP_L2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           level_in,
  input  logic                 hit_valid,
  input  logic [1:0]           hit_row,
  input  logic [2:0]           hit_col,
  output logic [ROWS*COLS-1:0] alive,
  output logic [9:0]           origin_x,
  output logic [9:0]           origin_y,
  output logic                 active,
  output logic                 win,
  output logic                 tank_destroyed,
  output logic [7:0]           score
);

  import space_monsters_pkg::*;

  localparam int N  = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [4:0]    state;
  logic          dir_left;
  logic          level_two;
  logic [31:0]   step_cnt;
  logic [31:0]   period;
  logic [RW-1:0] low_row;
  logic          any_alive;
  logic          start_ok;
  logic          step_fire;
  logic          right_hit;
  logic          left_hit;
  logic [10:0]   row_depth;
  logic          reached_tank;
  logic          hit_ok;
  logic [7:0]    hit_pos;
  logic [N-1:0]  hit_mask;
  logic          kill;

  lowest_alive_row #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_lowest (
    .alive     (alive),
    .row_idx   (low_row),
    .any_alive (any_alive)
  );

  assign start_ok  = start && level_ok(level_in);
  assign step_fire = (step_cnt == period - 32'd1);

  // Edge tests widened to 11 bits so the sums never wrap
  assign right_hit    = ({1'b0, origin_x} + 11'(COLS * CELL_W) + 11'(STEP_X)) > 11'(X_MAX);
  assign left_hit     = {1'b0, origin_x} < 11'(X_MIN + STEP_X);
  assign row_depth    = (11'(low_row) + 11'd1) * 11'(CELL_H);
  assign reached_tank = ({1'b0, origin_y} + row_depth) >= 11'(Y_TANK);

  assign hit_ok   = hit_valid && (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
  assign hit_pos  = 8'(hit_row) * 8'(COLS) + 8'(hit_col);
  assign hit_mask = hit_ok ? ({{(N-1){1'b0}}, 1'b1} << hit_pos) : '0;
  assign kill     = |(hit_mask & alive);

  // A valid start from any state but LOAD restarts the level; otherwise
  // MARCH settles outcomes before applying steps and hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      alive          <= '0;
      origin_x       <= 10'(X_MIN);
      origin_y       <= 10'(Y_START);
      dir_left       <= 1'b0;
      step_cnt       <= '0;
      period         <= 32'(STEP_L1);
      level_two      <= 1'b0;
      score          <= '0;
      win            <= 1'b0;
      tank_destroyed <= 1'b0;
      active         <= 1'b0;
    end else if (start_ok && state != ST_LOAD) begin
      state     <= ST_LOAD;
      level_two <= (level_in == 3'd2);
      active    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          alive          <= '1;
          origin_x       <= 10'(X_MIN);
          origin_y       <= 10'(Y_START);
          dir_left       <= 1'b0;
          step_cnt       <= '0;
          period         <= level_two ? 32'(STEP_L2) : 32'(STEP_L1);
          win            <= 1'b0;
          tank_destroyed <= 1'b0;
          if (!level_two) score <= '0;
          active         <= 1'b1;
          state          <= ST_MARCH;
        end
        ST_MARCH: begin
          if (!any_alive) begin
            state  <= ST_WON;
            win    <= 1'b1;
            active <= 1'b0;
          end else if (reached_tank) begin
            state          <= ST_LOST;
            tank_destroyed <= 1'b1;
            active         <= 1'b0;
          end else begin
            if (step_fire) begin
              step_cnt <= '0;
              if (!dir_left && right_hit) begin
                origin_y <= origin_y + 10'(DROP_Y);
                dir_left <= 1'b1;
              end else if (dir_left && left_hit) begin
                origin_y <= origin_y + 10'(DROP_Y);
                dir_left <= 1'b0;
              end else if (dir_left) begin
                origin_x <= origin_x - 10'(STEP_X);
              end else begin
                origin_x <= origin_x + 10'(STEP_X);
              end
            end else begin
              step_cnt <= step_cnt + 32'd1;
            end
            alive <= alive & ~hit_mask;
            if (kill && score != 8'hFF) score <= score + 8'd1;
          end
        end
        ST_IDLE, ST_WON, ST_LOST: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
